// File: rtl/ahbl_uart_loader_if.sv
// AHB-Lite write-master bundle used by the UART boot loader.
interface ahbl_uart_loader_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADY
    );
endinterface

// File: rtl/ahbl_uart_loader.sv
// UART-to-AHB-Lite boot loader: framed image in, word writes out.
// Define UART_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module ahbl_uart_loader #(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               rx,
    ahbl_uart_loader_if.master bus,
    output logic               load_active,
    output logic               load_done,
    output logic               load_error
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] SYNC = 8'h5A;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

`ifdef UART_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_FLUSH
    } state_t;
    localparam state_t S_TAIL = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_FLUSH
    } state_t;
    localparam state_t S_TAIL = S_FLUSH;
`endif

    rstate_t     rstate, rstate_n;
    logic        rx_s1, rx_s, rx_prev;
    logic [CW-1:0] rcnt;
    logic [2:0]  rbit;
    logic [7:0]  rshift, rx_byte;
    logic        byte_valid, frame_err, bit_tick;

    state_t      state, state_n;
    logic [7:0]  len_lo;
    logic [15:0] n_words, widx;
    logic [1:0]  bidx;
    logic [31:0] word, hold, haddr, hwdata, tcnt;
    logic        a_valid, d_valid;
    logic        issue, overrun, done, fail, timeout, last_word, chk_bad;

    // UART receiver
    always_comb begin
        bit_tick = (rstate == R_START) ? (rcnt == HALF_END)
                                       : (rcnt == BIT_END);
        rstate_n = rstate;
        unique case (rstate)
            R_IDLE:  if (rx_prev && !rx_s) rstate_n = R_START;
            R_START: if (bit_tick) rstate_n = rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (bit_tick && rbit == 3'd7) rstate_n = R_STOP;
            R_STOP:  if (bit_tick) rstate_n = R_IDLE;
            default: rstate_n = R_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rstate <= R_IDLE;
        end else begin
            rstate <= rstate_n;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_s1      <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            rcnt       <= '0;
            rbit       <= 3'd0;
            rshift     <= 8'd0;
            rx_byte    <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s       <= rx_s1;
            rx_prev    <= rx_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (rstate == R_IDLE || bit_tick) rcnt <= '0;
            else rcnt <= rcnt + 1'b1;
            if (rstate == R_START) rbit <= 3'd0;
            if (rstate == R_DATA && bit_tick) begin
                rshift <= {rx_s, rshift[7:1]};
                rbit   <= rbit + 3'd1;
            end
            if (rstate == R_STOP && bit_tick) begin
                if (rx_s) begin
                    byte_valid <= 1'b1;
                    rx_byte    <= rshift;
                end else begin
                    frame_err  <= 1'b1;
                end
            end
        end
    end

    // Loader control
    assign last_word = (widx + 16'd1 == n_words);
    assign timeout   = load_active && (tcnt == TIMEOUT_CYCLES);

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        overrun = 1'b0;
        done    = 1'b0;
        fail    = 1'b0;
        unique case (state)
            S_IDLE: if (byte_valid && rx_byte == SYNC) state_n = S_LEN0;
            S_LEN0: if (byte_valid) state_n = S_LEN1;
            S_LEN1: if (byte_valid)
                state_n = ({rx_byte, len_lo} == 16'd0) ? S_TAIL : S_DATA;
            S_DATA: if (byte_valid && bidx == 2'd3) begin
                if (a_valid) overrun = 1'b1;
                else issue = 1'b1;
                if (last_word) state_n = S_TAIL;
            end
`ifdef UART_LOADER_CHECKSUM_EN
            S_CHK: if (byte_valid) state_n = S_FLUSH;
`endif
            S_FLUSH: if (!a_valid && !d_valid) begin
                state_n = S_IDLE;
                if (chk_bad) fail = 1'b1;
                else done = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        if (state != S_IDLE && (frame_err || timeout || overrun)) begin
            state_n = S_IDLE;
            fail    = 1'b1;
            done    = 1'b0;
            issue   = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] chk_acc;
    logic       chk_bad_q;
    assign chk_bad = chk_bad_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            chk_acc   <= 8'd0;
            chk_bad_q <= 1'b0;
        end else if (state == S_IDLE) begin
            chk_acc   <= 8'd0;
            chk_bad_q <= 1'b0;
        end else if (byte_valid && state == S_DATA) begin
            chk_acc   <= chk_acc ^ rx_byte;
        end else if (byte_valid && state == S_CHK) begin
            chk_bad_q <= (rx_byte != chk_acc);
        end
    end
`else
    assign chk_bad = 1'b0;
`endif

    // Datapath and AHB-Lite master
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            len_lo  <= 8'd0;
            n_words <= 16'd0;
            widx    <= 16'd0;
            bidx    <= 2'd0;
            word    <= 32'd0;
            hold    <= 32'd0;
            haddr   <= 32'd0;
            hwdata  <= 32'd0;
            a_valid <= 1'b0;
            d_valid <= 1'b0;
            tcnt    <= 32'd0;
        end else begin
            if (!load_active || byte_valid) tcnt <= 32'd0;
            else if (!timeout) tcnt <= tcnt + 32'd1;
            // An edge with HREADY ends any data phase and accepts the address
            if (bus.HREADY) begin
                d_valid <= a_valid;
                if (a_valid) begin
                    hwdata  <= hold;
                    a_valid <= 1'b0;
                end
            end
            if (issue) begin
                a_valid <= 1'b1;
                haddr   <= BASE_ADDR + {14'd0, widx, 2'b00};
                hold    <= {rx_byte, word[31:8]};
                widx    <= widx + 16'd1;
            end
            if (state == S_IDLE) begin
                widx <= 16'd0;
                bidx <= 2'd0;
            end
            if (byte_valid && state == S_LEN0) len_lo <= rx_byte;
            if (byte_valid && state == S_LEN1) n_words <= {rx_byte, len_lo};
            if (byte_valid && state == S_DATA) begin
                word <= {rx_byte, word[31:8]};
                bidx <= bidx + 2'd1;
            end
        end
    end

    assign bus.HADDR   = haddr;
    assign bus.HTRANS  = a_valid ? 2'b10 : 2'b00;
    assign bus.HWRITE  = a_valid;
    assign bus.HSIZE   = 3'b010;
    assign bus.HWDATA  = hwdata;
    assign load_active = (state != S_IDLE);
    assign load_done   = done;
    assign load_error  = fail;
endmodule

// File: tb/tb_ahbl_uart_loader.sv
// Self-checking bench for ahbl_uart_loader: directed frames plus random
// frames checked against a byte-level frame model.
module tb_ahbl_uart_loader;
    localparam int CPB = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int TMO = 400;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic rx = 1'b1;
    logic load_active, load_done, load_error;

    ahbl_uart_loader_if bus ();

    ahbl_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR(BASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .rx(rx),
        .bus(bus.master),
        .load_active(load_active),
        .load_done(load_done),
        .load_error(load_error)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int fails = 0;

    // 0 ready, 1 three-cycle stall per phase, 2 random, 3 held low
    int hmode = 0;
    int scnt = 0;
    bit dph = 0, pa = 0, pd = 0, nd, busy;
    logic [31:0] dp_addr, pa_v, pd_v;
    int stall_viol = 0, stall_seen = 0, proto_viol = 0;
    int done_cnt = 0, err_cnt = 0;
    logic [31:0] wr_a[$], wr_d[$];

    logic [7:0]  frame[$], data_b[$];
    logic [31:0] exp_a[$], exp_d[$];
    bit exp_ok;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave model: drives HREADY and records completed writes
    initial begin
        bus.HREADY = 1'b1;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                dph = 0; pa = 0; pd = 0; scnt = 0;
                bus.HREADY = (hmode != 3);
            end else begin
                busy = (bus.HTRANS == 2'b10) || dph;
                case (hmode)
                    1: if (busy && scnt < 3) begin
                        bus.HREADY = 1'b0; scnt++;
                    end else begin
                        bus.HREADY = 1'b1; scnt = 0;
                    end
                    2: bus.HREADY = ($urandom_range(0, 2) != 0);
                    3: bus.HREADY = 1'b0;
                    default: bus.HREADY = 1'b1;
                endcase
                if (pa && (bus.HTRANS != 2'b10 || bus.HADDR != pa_v))
                    stall_viol++;
                if (pd && (!dph || bus.HWDATA != pd_v))
                    stall_viol++;
                pa = (bus.HTRANS == 2'b10) && !bus.HREADY;
                pa_v = bus.HADDR;
                pd = dph && !bus.HREADY;
                pd_v = bus.HWDATA;
                if (pa || pd) stall_seen++;
                if (bus.HTRANS == 2'b10 &&
                    (bus.HWRITE !== 1'b1 || bus.HSIZE !== 3'b010))
                    proto_viol++;
                if (bus.HTRANS != 2'b00 && bus.HTRANS != 2'b10)
                    proto_viol++;
                if (dph && bus.HREADY) begin
                    wr_a.push_back(dp_addr);
                    wr_d.push_back(bus.HWDATA);
                end
                nd = (bus.HTRANS == 2'b10) && bus.HREADY;
                if (nd) dp_addr = bus.HADDR;
                dph = nd || (dph && !bus.HREADY);
                if (load_done) done_cnt++;
                if (load_error) err_cnt++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        repeat (CPB) @(negedge HCLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge HCLK);
        end
        rx = stop;
        repeat (CPB) @(negedge HCLK);
        rx = 1'b1;
        if (!stop) repeat (CPB) @(negedge HCLK);
    endtask

    // Frame model: header, data_b, optional checksum; writes = whole words
    task automatic build(input int n, input bit corrupt);
        logic [7:0] x;
        int nw;
        x = 8'h00;
        frame.delete();
        exp_a.delete();
        exp_d.delete();
        frame.push_back(8'h5A);
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        foreach (data_b[i]) begin
            frame.push_back(data_b[i]);
            x = x ^ data_b[i];
        end
        nw = data_b.size() / 4;
        for (int i = 0; i < nw; i++) begin
            exp_a.push_back(BASE + 32'(4 * i));
            exp_d.push_back({data_b[4*i+3], data_b[4*i+2],
                             data_b[4*i+1], data_b[4*i]});
        end
        exp_ok = (data_b.size() == 4 * n);
`ifdef UART_LOADER_CHECKSUM_EN
        if (exp_ok) begin
            frame.push_back(corrupt ? (x ^ 8'h01) : x);
            exp_ok = !corrupt;
        end
`else
        if (corrupt) exp_ok = 1'b0;
`endif
    endtask

    task automatic wait_result(input int d0, input int e0, input string tag);
        int k;
        k = 0;
        while (done_cnt == d0 && err_cnt == e0 && k < 3 * TMO) begin
            @(negedge HCLK);
            k++;
        end
        checks++;
        assert (k < 3 * TMO) else begin
            fails++;
            $error("FAIL %s_wait: observed no result expected a pulse", tag);
        end
        repeat (20) @(negedge HCLK);
    endtask

    task automatic check_result(input string tag, input int d0, input int e0);
        check({tag, "_nwr"}, wr_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < wr_a.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_a[i], exp_a[i]);
            check($sformatf("%s_data%0d", tag, i), wr_d[i], exp_d[i]);
        end
        check({tag, "_done"}, done_cnt - d0, exp_ok ? 1 : 0);
        check({tag, "_err"}, err_cnt - e0, exp_ok ? 0 : 1);
        check({tag, "_active"}, load_active, 1'b0);
    endtask

    task automatic run_frame(input string tag);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        wr_a.delete();
        wr_d.delete();
        foreach (frame[i]) send_byte(frame[i], 1'b1);
        wait_result(d0, e0, tag);
        check_result(tag, d0, e0);
    endtask

    initial begin
        int d0, e0, n;
        repeat (3) @(negedge HCLK);
        check("rst_htrans", bus.HTRANS, 2'b00);
        check("rst_haddr", bus.HADDR, 32'd0);
        check("rst_hwrite", bus.HWRITE, 1'b0);
        check("rst_hwdata", bus.HWDATA, 32'd0);
        check("rst_hsize", bus.HSIZE, 3'b010);
        check("rst_active", load_active, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_error", load_error, 1'b0);
        HRESETn = 1'b1;
        repeat (5) @(negedge HCLK);

        data_b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        build(2, 1'b0);
        run_frame("basic");

        hmode = 1;
        stall_viol = 0;
        stall_seen = 0;
        run_frame("stall");
        check("stall_stable", stall_viol, 0);
        check("stall_seen", stall_seen > 0, 1'b1);
        hmode = 0;

        data_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        build(1, 1'b0);
        frame.push_front(8'hFF);
        frame.push_front(8'h00);
        run_frame("garbage");

        data_b.delete();
        build(0, 1'b0);
        run_frame("zero");

        // framing error inside a frame
        d0 = done_cnt;
        e0 = err_cnt;
        wr_a.delete();
        wr_d.delete();
        send_byte(8'h5A, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        check("ferr_active", load_active, 1'b1);
        send_byte(8'h33, 1'b0);
        wait_result(d0, e0, "ferr");
        data_b.delete();
        build(1, 1'b1);
        check_result("ferr", d0, e0);
        data_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        build(1, 1'b0);
        run_frame("after_ferr");

        data_b = '{8'h01, 8'h02, 8'h03, 8'h04};
        build(3, 1'b0);
        run_frame("timeout");

`ifdef UART_LOADER_CHECKSUM_EN
        data_b = '{8'h01, 8'h02, 8'h03, 8'h04};
        build(1, 1'b0);
        frame[frame.size() - 1] = 8'h05;
        exp_ok = 1'b0;
        run_frame("chk_bad");
        build(1, 1'b0);
        check("chk_byte", frame[frame.size() - 1], 8'h04);
        run_frame("chk_good");
`endif

        hmode = 2;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 3);
            data_b.delete();
            for (int i = 0; i < 4 * n; i++) data_b.push_back(8'($urandom));
            build(n, $urandom_range(0, 3) == 0);
            run_frame($sformatf("rand%0d", r));
        end
        hmode = 0;
        check("proto", proto_viol, 0);

        // asynchronous reset with an address phase stuck in a stall
        hmode = 3;
        wr_a.delete();
        wr_d.delete();
        data_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        build(1, 1'b0);
        foreach (frame[i]) send_byte(frame[i], 1'b1);
        repeat (10) @(negedge HCLK);
        check("stuck_htrans", bus.HTRANS, 2'b10);
        check("stuck_active", load_active, 1'b1);
        #3 HRESETn = 1'b0;
        #1;
        check("arst_htrans", bus.HTRANS, 2'b00);
        check("arst_haddr", bus.HADDR, 32'd0);
        check("arst_hwrite", bus.HWRITE, 1'b0);
        check("arst_active", load_active, 1'b0);
        hmode = 0;
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (5) @(negedge HCLK);
        check("arst_nwr", wr_a.size(), 0);
        data_b = '{8'h10, 8'h32, 8'h54, 8'h76};
        build(1, 1'b0);
        run_frame("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
